// File: rtl/axi_lite_rd_seq_if.sv
// Command, read-FSM handshake and buffer-write signals of the AXI4-Lite read sequencer.
// The master modport is the sequencer's view; slave is the environment's.
interface axi_lite_rd_seq_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
);
    logic              go;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words;
    logic              start;
    logic [ADDR_W-1:0] araddr;
    logic              done_flag;
    logic              en_mem_wr;
    logic [DATA_W-1:0] rdata;
    logic              mem_we;
    logic [CNT_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              seq_done;
    logic              error;
    logic [CNT_W-1:0]  words_done;

    modport master (
        input  go, base_addr, num_words, done_flag, en_mem_wr, rdata,
        output start, araddr, mem_we, mem_addr, mem_wdata, busy, seq_done, error, words_done
    );

    modport slave (
        output go, base_addr, num_words, done_flag, en_mem_wr, rdata,
        input  start, araddr, mem_we, mem_addr, mem_wdata, busy, seq_done, error, words_done
    );
endinterface

// File: rtl/axi_lite_rd_seq.sv
// Turns one go command into num_words sequential single-beat reads via the read FSM,
// storing each OKAY beat into a buffer at an incrementing index; a watchdog flags stalls.
module axi_lite_rd_seq #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned STRIDE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_lite_rd_seq_if.master  io_bus
);
    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_FINISH, S_ERR} state_e;

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
    logic              r_start, w_start_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_seq_done, w_seq_done_nxt;
    logic              r_error, w_error_nxt;
    logic [CNT_W-1:0]  r_words_done, w_words_done_nxt;
    logic [WD_W-1:0]   r_wd, w_wd_nxt;
    logic [CNT_W-1:0]  r_idx, w_idx_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [CNT_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_araddr     <= '0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_seq_done   <= 1'b0;
            r_error      <= 1'b0;
            r_words_done <= '0;
            r_wd         <= '0;
            r_idx        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_araddr     <= w_araddr_nxt;
            r_start      <= w_start_nxt;
            r_busy       <= w_busy_nxt;
            r_seq_done   <= w_seq_done_nxt;
            r_error      <= w_error_nxt;
            r_words_done <= w_words_done_nxt;
            r_wd         <= w_wd_nxt;
            r_idx        <= w_idx_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_araddr_nxt     = r_araddr;
        w_start_nxt      = 1'b0;
        w_busy_nxt       = r_busy;
        w_seq_done_nxt   = 1'b0;
        w_error_nxt      = r_error;
        w_words_done_nxt = r_words_done;
        w_wd_nxt         = r_wd;
        w_idx_nxt        = r_idx;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;

        unique case (r_state)
            S_IDLE: begin
                if (io_bus.go) begin
                    if (io_bus.num_words != '0) begin
                        w_count_nxt      = io_bus.num_words;
                        w_araddr_nxt     = io_bus.base_addr;
                        w_error_nxt      = 1'b0;
                        w_words_done_nxt = '0;
                        w_idx_nxt        = '0;
                        w_busy_nxt       = 1'b1;
                        w_state_nxt      = S_ISSUE;
                    end else begin
                        w_seq_done_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_start_nxt = 1'b1;
                w_wd_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_wd_nxt = r_wd + WD_W'(1);
                // A completion on the expiry cycle still counts as a good read.
                if (io_bus.done_flag) begin
                    w_words_done_nxt = r_words_done + CNT_W'(1);
                    w_state_nxt      = S_NEXT;
                end else if (r_wd == WD_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_NEXT: begin
                if (r_words_done == r_count) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_araddr_nxt = r_araddr + ADDR_W'(STRIDE);
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_FINISH: begin
                w_seq_done_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = S_IDLE;
            end
            S_ERR: begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Buffer writes follow en_mem_wr regardless of state, except when no command is active.
        if (io_bus.en_mem_wr && (r_state != S_IDLE) && (r_state != S_ERR)) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_idx;
            w_mem_wdata_nxt = io_bus.rdata;
            w_idx_nxt       = r_idx + CNT_W'(1);
        end
    end

    assign io_bus.start      = r_start;
    assign io_bus.araddr     = r_araddr;
    assign io_bus.busy       = r_busy;
    assign io_bus.seq_done   = r_seq_done;
    assign io_bus.error      = r_error;
    assign io_bus.words_done = r_words_done;
    assign io_bus.mem_we     = r_mem_we;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_axi_lite_rd_seq.sv
// Directed bench for axi_lite_rd_seq: a scripted read-FSM responder plus a negedge monitor
// that logs start addresses, buffer writes and seq_done pulses.
module tb_axi_lite_rd_seq;
    logic clk;
    logic rst_n;

    axi_lite_rd_seq_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(8)) bus ();

    axi_lite_rd_seq #(
        .ADDR_W (32),
        .DATA_W (32),
        .CNT_W  (8),
        .STRIDE (4),
        .TIMEOUT(1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q_addr[$];
    logic [7:0]  q_widx[$];
    logic [31:0] q_wdat[$];
    int          n_seq_done = 0;
    bit          busy_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.start) q_addr.push_back(bus.araddr);
        if (bus.mem_we) begin
            q_widx.push_back(bus.mem_addr);
            q_wdat.push_back(bus.mem_wdata);
        end
        if (bus.seq_done) n_seq_done++;
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_widx.delete();
        q_wdat.delete();
        n_seq_done = 0;
        busy_seen  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic go_cmd(input logic [31:0] base, input logic [7:0] num);
        @(negedge clk);
        bus.go        = 1'b1;
        bus.base_addr = base;
        bus.num_words = num;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.start && cyc < 50);
        if (!bus.start) chk("start_timeout", 0, 1);
    endtask

    // Answers one read: completion with OKAY data one cycle after start is seen.
    task automatic run_word(input logic [31:0] data, input bit poke_go, output int lat);
        wait_start(lat);
        if (poke_go) begin
            bus.go        = 1'b1;
            bus.base_addr = 32'h9000;
            bus.num_words = 8'd5;
        end
        @(negedge clk);
        bus.go        = 1'b0;
        bus.done_flag = 1'b1;
        bus.en_mem_wr = 1'b1;
        bus.rdata     = data;
        @(negedge clk);
        bus.done_flag = 1'b0;
        bus.en_mem_wr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, bus.start, 0);
        chk({tag, "_araddr"}, bus.araddr, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_words_done"}, bus.words_done, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_seq_done"}, bus.seq_done, 0);
        chk({tag, "_error"}, bus.error, 0);
    endtask

    initial begin
        int lat;
        int cnt;
        rst_n         = 1'b0;
        bus.go        = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.done_flag = 1'b0;
        bus.en_mem_wr = 1'b0;
        bus.rdata     = '0;
        #12;
        chk_all_zero("reset");
        do_reset();

        // Three-word read
        go_cmd(32'h1000, 8'd3);
        run_word(32'hA0, 1'b0, lat);
        chk("lat_go_to_start", lat, 1);
        run_word(32'hA1, 1'b0, lat);
        chk("lat_done_to_start1", lat, 2);
        run_word(32'hA2, 1'b0, lat);
        chk("lat_done_to_start2", lat, 2);
        repeat (4) @(negedge clk);
        chk("t1_nstart", q_addr.size(), 3);
        chk("t1_addr0", q_addr[0], 32'h1000);
        chk("t1_addr1", q_addr[1], 32'h1004);
        chk("t1_addr2", q_addr[2], 32'h1008);
        chk("t1_nwr", q_wdat.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_widx", q_widx[i], i);
            chk("t1_wdat", q_wdat[i], 32'hA0 + i);
        end
        chk("t1_words_done", bus.words_done, 3);
        chk("t1_seq_done_cnt", n_seq_done, 1);
        chk("t1_busy", bus.busy, 0);
        chk("t1_error", bus.error, 0);

        // Zero-length command
        clear_log();
        go_cmd(32'h5000, 8'd0);
        chk("t2_seq_done", bus.seq_done, 1);
        chk("t2_busy", bus.busy, 0);
        @(negedge clk);
        chk("t2_seq_done_drop", bus.seq_done, 0);
        repeat (5) @(negedge clk);
        chk("t2_nstart", q_addr.size(), 0);
        chk("t2_busy_seen", busy_seen, 0);
        chk("t2_seq_done_cnt", n_seq_done, 1);

        // SLVERR on word 2: the read FSM never completes, watchdog fires
        clear_log();
        go_cmd(32'h100, 8'd4);
        run_word(32'h55, 1'b0, lat);
        wait_start(lat);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.error && cnt < 1200);
        chk("t3_timeout_cycles", cnt, 1025);
        chk("t3_error", bus.error, 1);
        chk("t3_busy", bus.busy, 0);
        chk("t3_words_done", bus.words_done, 1);
        chk("t3_nwr", q_wdat.size(), 1);
        chk("t3_wdat", q_wdat[0], 32'h55);
        chk("t3_seq_done_cnt", n_seq_done, 0);
        do_reset();
        chk_all_zero("t3_post_reset");

        // Address wrap
        go_cmd(32'hFFFF_FFFC, 8'd2);
        run_word(32'h11, 1'b0, lat);
        run_word(32'h22, 1'b0, lat);
        repeat (4) @(negedge clk);
        chk("t4_addr0", q_addr[0], 32'hFFFF_FFFC);
        chk("t4_addr1", q_addr[1], 32'h0000_0000);
        chk("t4_words_done", bus.words_done, 2);

        // go while busy is ignored
        clear_log();
        go_cmd(32'h2000, 8'd2);
        run_word(32'hB0, 1'b1, lat);
        run_word(32'hB1, 1'b0, lat);
        repeat (6) @(negedge clk);
        chk("t5_nstart", q_addr.size(), 2);
        chk("t5_addr0", q_addr[0], 32'h2000);
        chk("t5_addr1", q_addr[1], 32'h2004);
        chk("t5_words_done", bus.words_done, 2);
        chk("t5_seq_done_cnt", n_seq_done, 1);
        chk("t5_widx0", q_widx[0], 0);
        chk("t5_widx1", q_widx[1], 1);
        chk("t5_busy", bus.busy, 0);

        // Reset during word 2 wait, then a clean command
        clear_log();
        go_cmd(32'h3000, 8'd3);
        run_word(32'hC0, 1'b0, lat);
        wait_start(lat);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("t6_seq_done_cnt", n_seq_done, 0);
        clear_log();
        go_cmd(32'h4000, 8'd2);
        run_word(32'hD0, 1'b0, lat);
        run_word(32'hD1, 1'b0, lat);
        repeat (4) @(negedge clk);
        chk("t6_addr0", q_addr[0], 32'h4000);
        chk("t6_addr1", q_addr[1], 32'h4004);
        chk("t6_widx0", q_widx[0], 0);
        chk("t6_widx1", q_widx[1], 1);
        chk("t6_wdat0", q_wdat[0], 32'hD0);
        chk("t6_wdat1", q_wdat[1], 32'hD1);
        chk("t6_seq_done_cnt", n_seq_done, 1);
        chk("t6_error", bus.error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
